// File: rtl/ct_idu_dep_pkg.sv
// Shared encodings, field offsets and helpers for the IDU source dependency tracking entry.
package ct_idu_dep_pkg;

  localparam logic [1:0] DEP_WAIT = 2'd0;
  localparam logic [1:0] DEP_RDY  = 2'd1;
  localparam logic [1:0] DEP_SPEC = 2'd2;
  localparam logic [1:0] DEP_DONE = 2'd3;

  // x_read_data fields; the upper three sit above the PREG_W-wide preg field
  localparam int RD_SPEC    = 0;
  localparam int RD_RDY_NXT = 1;
  localparam int RD_WB_NXT  = 2;
  localparam int RD_PREG    = 3;

  localparam int CR_RDY  = 0;
  localparam int CR_WB   = 1;
  localparam int CR_PREG = 2;

  function automatic int rd_issue_off(input int preg_w);
    return preg_w + 3;
  endfunction

  function automatic int rd_bypass_off(input int preg_w);
    return preg_w + 4;
  endfunction

  function automatic int rd_lsu_off(input int preg_w);
    return preg_w + 5;
  endfunction

  function automatic int cr_lsu_off(input int preg_w);
    return preg_w + 2;
  endfunction

  function automatic int dep_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int dep_idx_w(input int n);
    return (n > 1) ? dep_clog2(n) : 1;
  endfunction

  function automatic logic [1:0] dep_state(input logic rdy, input logic wb, input logic spec);
    if (wb)               return DEP_DONE;
    else if (rdy && spec) return DEP_SPEC;
    else if (rdy)         return DEP_RDY;
    else                  return DEP_WAIT;
  endfunction

endpackage

// File: rtl/ct_idu_dep_preg_cmp.sv
// N-way valid-qualified preg comparator; reports any hit and the lowest hitting channel.
module ct_idu_dep_preg_cmp
  import ct_idu_dep_pkg::*;
#(
  parameter int N      = 4,
  parameter int PREG_W = 7,
  localparam int IDX_W = dep_idx_w(N)
) (
  input  logic [N-1:0]        vld_i,
  input  logic [N*PREG_W-1:0] preg_i,
  input  logic [PREG_W-1:0]   ref_i,
  output logic                any_hit_o,
  output logic [IDX_W-1:0]    hit_idx_o
);

  logic [N-1:0] hit;

  // Scan downward so the lowest hitting channel is the last one written
  always_comb begin
    hit       = '0;
    hit_idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      hit[i] = vld_i[i] & (preg_i[i*PREG_W +: PREG_W] == ref_i);
      if (hit[i]) hit_idx_o = IDX_W'(i);
    end
  end

  assign any_hit_o = |hit;

endmodule

// File: rtl/ct_idu_dep_preg_track_entry.sv
// Per-source dependency tracking entry: follows one preg through WAIT/SPEC/RDY/DONE.
// state | meaning
// WAIT  | producer outstanding, not ready
// SPEC  | ready on a speculative load wakeup, cancellable, ages out
// RDY   | ready, result not yet written back
// DONE  | written back (also the reset/flush state)
module ct_idu_dep_preg_track_entry
  import ct_idu_dep_pkg::*;
#(
  parameter int PREG_W   = 7,
  parameter int WAKE_N   = 4,
  parameter int WB_N     = 3,
  parameter int LD_N     = 2,
  parameter int SPEC_MAX = 4
) (
  input  logic                   dep_clk,
  input  logic                   cpurst_b,
  input  logic                   flush,
  input  logic                   x_write_en,
  input  logic [PREG_W+2:0]      x_create_data,
  input  logic                   x_rdy_clr,
  input  logic [WAKE_N-1:0]      wake_vld,
  input  logic [WAKE_N*PREG_W-1:0] wake_preg,
  input  logic [WAKE_N-1:0]      fwd_vld,
  input  logic [WB_N-1:0]        wb_vld,
  input  logic [WB_N*PREG_W-1:0] wb_preg,
  input  logic [LD_N-1:0]        ld_spec_vld,
  input  logic [LD_N*PREG_W-1:0] ld_spec_preg,
  input  logic [LD_N-1:0]        ld_cancel,
  input  logic [LD_N-1:0]        ld_ag_vld,
  input  logic [LD_N*PREG_W-1:0] ld_ag_preg,
  output logic [PREG_W+5:0]      x_read_data,
  output logic                   x_clk_en
);

  localparam int CH_W    = dep_idx_w(LD_N);
  localparam int WK_W    = dep_idx_w(WAKE_N);
  localparam int WB_W    = dep_idx_w(WB_N);
  localparam int AGE_W   = dep_clog2(SPEC_MAX + 1);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(SPEC_MAX - 1);

  logic              rdy_q, rdy_d, wb_q, wb_d, spec_q, spec_d, lsu_q, lsu_d;
  logic [CH_W-1:0]   spec_ch_q, spec_ch_d;
  logic [AGE_W-1:0]  age_q, age_d;
  logic [PREG_W-1:0] preg_q, preg_d;
  logic              rdy_e, wb_e, spec_e;
  logic [CH_W-1:0]   ch_e;
  logic [AGE_W-1:0]  age_e;
  logic              wk_hit, wb_hit, ld_hit, ag_hit;
  logic [CH_W-1:0]   ld_idx;
  logic [WK_W-1:0]   wk_idx_unused;
  logic [WB_W-1:0]   wb_idx_unused;
  logic [CH_W-1:0]   ag_idx_unused;
  logic [1:0]        st;

  ct_idu_dep_preg_cmp #(.N(WAKE_N), .PREG_W(PREG_W)) u_cmp_wake (
    .vld_i(wake_vld), .preg_i(wake_preg), .ref_i(preg_q),
    .any_hit_o(wk_hit), .hit_idx_o(wk_idx_unused));

  ct_idu_dep_preg_cmp #(.N(WB_N), .PREG_W(PREG_W)) u_cmp_wb (
    .vld_i(wb_vld), .preg_i(wb_preg), .ref_i(preg_q),
    .any_hit_o(wb_hit), .hit_idx_o(wb_idx_unused));

  ct_idu_dep_preg_cmp #(.N(LD_N), .PREG_W(PREG_W)) u_cmp_ld_spec (
    .vld_i(ld_spec_vld), .preg_i(ld_spec_preg), .ref_i(preg_q),
    .any_hit_o(ld_hit), .hit_idx_o(ld_idx));

  ct_idu_dep_preg_cmp #(.N(LD_N), .PREG_W(PREG_W)) u_cmp_ld_ag (
    .vld_i(ld_ag_vld), .preg_i(ld_ag_preg), .ref_i(preg_q),
    .any_hit_o(ag_hit), .hit_idx_o(ag_idx_unused));

  assign st = dep_state(rdy_q, wb_q, spec_q);

  // Event-driven next state; rdy_e also feeds rdy_nxt, so flush/create stay out of it
  always_comb begin
    rdy_e  = rdy_q;
    wb_e   = wb_q;
    spec_e = spec_q;
    ch_e   = spec_ch_q;
    age_e  = '0;
    if (wb_hit) begin
      rdy_e  = 1'b1;
      wb_e   = 1'b1;
      spec_e = 1'b0;
    end else if (x_rdy_clr && (st == DEP_RDY || st == DEP_SPEC)) begin
      rdy_e  = 1'b0;
      spec_e = 1'b0;
    end else if (st == DEP_SPEC) begin
      if (ld_cancel[spec_ch_q] || age_q == AGE_LAST) begin
        rdy_e  = 1'b0;
        spec_e = 1'b0;
      end else if (wk_hit) begin
        spec_e = 1'b0;
      end else begin
        age_e = age_q + 1'b1;
      end
    end else if (st == DEP_WAIT) begin
      if (wk_hit) begin
        rdy_e = 1'b1;
      end else if (ld_hit) begin
        rdy_e  = 1'b1;
        spec_e = 1'b1;
        ch_e   = ld_idx;
      end
    end
  end

  always_comb begin
    rdy_d     = rdy_e;
    wb_d      = wb_e;
    spec_d    = spec_e;
    spec_ch_d = ch_e;
    age_d     = age_e;
    preg_d    = preg_q;
    lsu_d     = ag_hit;
    if (flush) begin
      rdy_d  = 1'b1;
      wb_d   = 1'b1;
      spec_d = 1'b0;
      age_d  = '0;
      lsu_d  = 1'b0;
    end else if (x_write_en) begin
      rdy_d  = x_create_data[CR_RDY] | x_create_data[CR_WB];
      wb_d   = x_create_data[CR_WB];
      spec_d = 1'b0;
      age_d  = '0;
      preg_d = x_create_data[CR_PREG +: PREG_W];
      lsu_d  = x_create_data[cr_lsu_off(PREG_W)];
    end
  end

  always_ff @(posedge dep_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rdy_q     <= 1'b1;
      wb_q      <= 1'b1;
      spec_q    <= 1'b0;
      spec_ch_q <= '0;
      age_q     <= '0;
      preg_q    <= '0;
      lsu_q     <= 1'b0;
    end else begin
      rdy_q     <= rdy_d;
      wb_q      <= wb_d;
      spec_q    <= spec_d;
      spec_ch_q <= spec_ch_d;
      age_q     <= age_d;
      preg_q    <= preg_d;
      lsu_q     <= lsu_d;
    end
  end

  always_comb begin
    x_read_data                          = '0;
    x_read_data[RD_SPEC]                 = spec_q;
    x_read_data[RD_RDY_NXT]              = rdy_e;
    x_read_data[RD_WB_NXT]               = wb_q | wb_hit;
    x_read_data[RD_PREG +: PREG_W]       = preg_q;
    x_read_data[rd_issue_off(PREG_W)]    = rdy_q | (|fwd_vld) | (lsu_q & (|ld_spec_vld));
    x_read_data[rd_bypass_off(PREG_W)]   = rdy_q & ~spec_q;
    x_read_data[rd_lsu_off(PREG_W)]      = ag_hit;
  end

  assign x_clk_en = x_write_en | ~wb_q;

endmodule

// File: tb/tb_ct_idu_dep_preg_track_entry.sv
// Directed scoreboard bench for the dependency tracking entry (default parameters).
module tb_ct_idu_dep_preg_track_entry;

  logic        dep_clk = 1'b0;
  logic        cpurst_b;
  logic        flush, x_write_en, x_rdy_clr;
  logic [9:0]  x_create_data;
  logic [3:0]  wake_vld, fwd_vld;
  logic [27:0] wake_preg;
  logic [2:0]  wb_vld;
  logic [20:0] wb_preg;
  logic [1:0]  ld_spec_vld, ld_cancel, ld_ag_vld;
  logic [13:0] ld_spec_preg, ld_ag_preg;
  logic [12:0] x_read_data;
  logic        x_clk_en;

  typedef struct {
    string      nm;
    logic [12:0] rd;
    logic        en;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  ct_idu_dep_preg_track_entry dut (
    .dep_clk(dep_clk), .cpurst_b(cpurst_b), .flush(flush),
    .x_write_en(x_write_en), .x_create_data(x_create_data), .x_rdy_clr(x_rdy_clr),
    .wake_vld(wake_vld), .wake_preg(wake_preg), .fwd_vld(fwd_vld),
    .wb_vld(wb_vld), .wb_preg(wb_preg),
    .ld_spec_vld(ld_spec_vld), .ld_spec_preg(ld_spec_preg), .ld_cancel(ld_cancel),
    .ld_ag_vld(ld_ag_vld), .ld_ag_preg(ld_ag_preg),
    .x_read_data(x_read_data), .x_clk_en(x_clk_en));

  always #5 dep_clk = ~dep_clk;

  // Monitor: one expectation per cycle, sampled at the falling edge
  always @(negedge dep_clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_chk++;
      if (x_read_data !== e.rd || x_clk_en !== e.en) begin
        n_fail++;
        $display("FAIL %s: read_data=%h clk_en=%b, required read_data=%h clk_en=%b",
                 e.nm, x_read_data, x_clk_en, e.rd, e.en);
      end
    end
  end

  // {lsu_match_nxt, rdy_bypass, rdy_issue, preg, wb_nxt, rdy_nxt, spec}
  function automatic logic [12:0] rdv(input logic lsu, input logic byp, input logic iss,
                                      input logic [6:0] preg, input logic wbn,
                                      input logic rdyn, input logic spec);
    return {lsu, byp, iss, preg, wbn, rdyn, spec};
  endfunction

  task automatic chk(input string nm, input logic [12:0] rd, input logic en);
    exp_t e;
    e.nm = nm;
    e.rd = rd;
    e.en = en;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge dep_clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; x_write_en = 0; x_rdy_clr = 0; x_create_data = '0;
    wake_vld = '0; wake_preg = '0; fwd_vld = '0;
    wb_vld = '0; wb_preg = '0;
    ld_spec_vld = '0; ld_spec_preg = '0; ld_cancel = '0;
    ld_ag_vld = '0; ld_ag_preg = '0;
  endtask

  task automatic create(input logic lsu, input logic [6:0] preg, input logic wb, input logic rdy);
    x_write_en    = 1'b1;
    x_create_data = {lsu, preg, wb, rdy};
  endtask

  initial begin
    cpurst_b = 1'b0;
    idle();
    repeat (2) @(posedge dep_clk);
    #1;
    chk("reset", rdv(0,1,1,7'h00,1,1,0), 0); tick();
    cpurst_b = 1'b1;

    // create WAIT, wake, writeback
    idle(); create(0,7'h15,0,0); chk("t1_create", rdv(0,1,1,7'h00,1,1,0), 1); tick();
    idle(); wake_vld[2] = 1; wake_preg[14 +: 7] = 7'h15;
    chk("t1_wake_nxt", rdv(0,0,0,7'h15,0,1,0), 1); tick();
    idle(); chk("t1_rdy", rdv(0,1,1,7'h15,0,1,0), 1); tick();
    idle(); wb_vld[0] = 1; wb_preg[0 +: 7] = 7'h15;
    chk("t1_wb_nxt", rdv(0,1,1,7'h15,1,1,0), 1); tick();
    idle(); chk("t1_done", rdv(0,1,1,7'h15,1,1,0), 0); tick();

    // speculative wakeup and per-channel cancel
    idle(); create(0,7'h15,0,0); chk("t2_create", rdv(0,1,1,7'h15,1,1,0), 1); tick();
    idle(); ld_spec_vld[1] = 1; ld_spec_preg[7 +: 7] = 7'h15;
    chk("t2_ld_spec", rdv(0,0,0,7'h15,0,1,0), 1); tick();
    idle(); ld_cancel[0] = 1; chk("t2_cancel_other", rdv(0,0,1,7'h15,0,1,1), 1); tick();
    idle(); ld_cancel[1] = 1; chk("t2_cancel_own", rdv(0,0,1,7'h15,0,0,1), 1); tick();
    idle(); chk("t2_wait", rdv(0,0,0,7'h15,0,0,0), 1); tick();

    // age-out after exactly four SPEC cycles
    idle(); ld_spec_vld[0] = 1; ld_spec_preg[0 +: 7] = 7'h15;
    chk("t3_enter", rdv(0,0,0,7'h15,0,1,0), 1); tick();
    for (int a = 0; a < 3; a++) begin
      idle(); chk("t3_spec_hold", rdv(0,0,1,7'h15,0,1,1), 1); tick();
    end
    idle(); chk("t3_age_last", rdv(0,0,1,7'h15,0,0,1), 1); tick();
    idle(); chk("t3_aged_out", rdv(0,0,0,7'h15,0,0,0), 1); tick();

    // writeback at age 2 beats age-out
    idle(); ld_spec_vld[0] = 1; ld_spec_preg[0 +: 7] = 7'h15;
    chk("t3b_enter", rdv(0,0,0,7'h15,0,1,0), 1); tick();
    for (int a = 0; a < 2; a++) begin
      idle(); chk("t3b_spec_hold", rdv(0,0,1,7'h15,0,1,1), 1); tick();
    end
    idle(); wb_vld[1] = 1; wb_preg[7 +: 7] = 7'h15;
    chk("t3b_wb_age2", rdv(0,0,1,7'h15,1,1,1), 1); tick();
    idle(); chk("t3b_done", rdv(0,1,1,7'h15,1,1,0), 0); tick();

    // rdy_clr vs writeback priority
    idle(); create(0,7'h2A,0,1); chk("t4_create", rdv(0,1,1,7'h15,1,1,0), 1); tick();
    idle(); x_rdy_clr = 1; wb_vld[2] = 1; wb_preg[14 +: 7] = 7'h2A;
    chk("t4_clr_wb", rdv(0,1,1,7'h2A,1,1,0), 1); tick();
    idle(); chk("t4_done", rdv(0,1,1,7'h2A,1,1,0), 0); tick();
    idle(); create(0,7'h2A,0,1); chk("t4_create2", rdv(0,1,1,7'h2A,1,1,0), 1); tick();
    idle(); x_rdy_clr = 1; chk("t4_clr", rdv(0,1,1,7'h2A,0,0,0), 1); tick();
    idle(); chk("t4_wait", rdv(0,0,0,7'h2A,0,0,0), 1); tick();

    // flush beats create; create beats same-cycle wake
    idle(); flush = 1; create(0,7'h11,0,0);
    chk("t5_flush_create", rdv(0,0,0,7'h2A,0,0,0), 1); tick();
    idle(); chk("t5_flush_done", rdv(0,1,1,7'h2A,1,1,0), 0); tick();
    idle(); create(0,7'h33,0,0); wake_vld[0] = 1; wake_preg[0 +: 7] = 7'h33;
    chk("t5_create_wake", rdv(0,1,1,7'h2A,1,1,0), 1); tick();
    idle(); chk("t5_wake_lost", rdv(0,0,0,7'h33,0,0,0), 1); tick();

    // forward bypass and lsu_match issue path
    idle(); fwd_vld[3] = 1; chk("t6_fwd", rdv(0,0,1,7'h33,0,0,0), 1); tick();
    idle(); ld_ag_vld[1] = 1; ld_ag_preg[7 +: 7] = 7'h33;
    chk("t6_ag", rdv(1,0,0,7'h33,0,0,0), 1); tick();
    idle(); ld_spec_vld[0] = 1; ld_spec_preg[0 +: 7] = 7'h01;
    chk("t6_lsu_issue", rdv(0,0,1,7'h33,0,0,0), 1); tick();
    idle(); chk("t6_lsu_clear", rdv(0,0,0,7'h33,0,0,0), 1); tick();

    // SPEC confirmed by non-speculative wakeup
    idle(); ld_spec_vld[1] = 1; ld_spec_preg[7 +: 7] = 7'h33;
    chk("t7_enter", rdv(0,0,0,7'h33,0,1,0), 1); tick();
    idle(); wake_vld[1] = 1; wake_preg[7 +: 7] = 7'h33;
    chk("t7_confirm", rdv(0,0,1,7'h33,0,1,1), 1); tick();
    idle(); chk("t7_rdy", rdv(0,1,1,7'h33,0,1,0), 1); tick();

    // lowest channel recorded, cancel on the other ignored, async reset mid-SPEC
    idle(); x_rdy_clr = 1; chk("t8_clr", rdv(0,1,1,7'h33,0,0,0), 1); tick();
    idle(); ld_spec_vld = 2'b11; ld_spec_preg = {7'h33, 7'h33};
    chk("t8_enter_both", rdv(0,0,0,7'h33,0,1,0), 1); tick();
    idle(); ld_cancel[1] = 1; chk("t8_cancel_hi", rdv(0,0,1,7'h33,0,1,1), 1); tick();
    idle(); cpurst_b = 1'b0; chk("t8_async_rst", rdv(0,1,1,7'h00,1,1,0), 0); tick();
    cpurst_b = 1'b1;
    idle(); chk("t8_post_rst", rdv(0,1,1,7'h00,1,1,0), 0); tick();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
